// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the zoom-pipeline memory-access sequencer:
// op codes, FSM states and the per-group read/write count table.
package mem_ctrl_pkg;

  localparam logic [2:0] OP_RD  = 3'b001;
  localparam logic [2:0] OP_WR  = 3'b010;
  localparam logic [2:0] OP_NHI = 3'b011;
  localparam logic [2:0] OP_PR  = 3'b100;
  localparam logic [2:0] OP_NH  = 3'b101;
  localparam logic [2:0] OP_BA  = 3'b110;

  localparam int unsigned CntW = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StWrite = 2'd2
  } state_e;

  typedef struct packed {
    logic [CntW-1:0] rd;
    logic [CntW-1:0] wr;
  } rw_t;

  function automatic logic op_legal(input logic [2:0] op);
    return (op != 3'b000) && (op != 3'b111);
  endfunction

  function automatic logic single_group(input logic [2:0] op);
    return (op == OP_RD) || (op == OP_WR);
  endfunction

  // Reads and writes issued per group for a given algorithm and zoom exponent.
  function automatic rw_t per_group_rw(input logic [2:0] op, input logic [2:0] z);
    rw_t rw;
    rw = '0;
    case (op)
      OP_RD:  rw.rd = CntW'(1);
      OP_WR:  rw.wr = CntW'(1);
      OP_NHI: begin rw.rd = CntW'(1); rw.wr = CntW'(1) << z;          end
      OP_PR:  begin rw.rd = CntW'(1); rw.wr = CntW'(1) << {z, 1'b0};  end
      OP_NH:  begin rw.rd = CntW'(1); rw.wr = CntW'(1);               end
      OP_BA:  begin rw.rd = CntW'(1) << z; rw.wr = CntW'(1);          end
      default: rw = '0;
    endcase
    return rw;
  endfunction

endpackage

// File: rtl/addr_stepper.sv
// Loadable frame-buffer pointer with a variable increment that wraps at MEM_DEPTH.
// o_ptr_next is the pointer value that will be held after the coming clock edge.
module addr_stepper #(
  parameter int unsigned ADDR_W    = 17,
  parameter int unsigned MEM_DEPTH = 76800
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_val,
  input  logic              i_step,
  input  logic [ADDR_W-1:0] i_inc,
  output logic [ADDR_W-1:0] o_ptr_next
);

  localparam logic [ADDR_W:0] Depth = (ADDR_W+1)'(MEM_DEPTH);

  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   w_sum;
  logic [ADDR_W-1:0] w_wrapped;

  always_comb begin
    w_sum     = {1'b0, r_ptr} + {1'b0, i_inc};
    w_wrapped = (w_sum >= Depth) ? ADDR_W'(w_sum - Depth) : ADDR_W'(w_sum);
    if (i_load) begin
      o_ptr_next = i_load_val;
    end else if (i_step) begin
      o_ptr_next = w_wrapped;
    end else begin
      o_ptr_next = r_ptr;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= o_ptr_next;
    end
  end

endmodule

// File: rtl/mem_access_sequencer.sv
// Generates the read/write address stream of one zoom algorithm per command,
// holding every access for WAIT_CYCLES+1 cycles. All outputs are registered.
module mem_access_sequencer
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned MEM_DEPTH   = 76800,
  parameter int unsigned LEN_W       = 17,
  parameter int unsigned WAIT_CYCLES = 3,
  parameter int unsigned MAX_ZOOM    = 2
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic [2:0]        i_operation,
  input  logic [2:0]        i_current_zoom,
  input  logic [ADDR_W-1:0] i_addr_base,
  input  logic [ADDR_W-1:0] i_addr_dst,
  input  logic [LEN_W-1:0]  i_length,
  input  logic              i_abort,
  output logic [ADDR_W-1:0] o_addr_out,
  output logic              o_wr_enable,
  output logic              o_rd_valid,
  output logic              o_rd_last,
  output logic              o_done,
  output logic              o_err,
  output logic [LEN_W-1:0]  o_step_count
);

  localparam int unsigned    WcW    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [WcW-1:0] WcLast = WcW'(WAIT_CYCLES);

  state_e            r_state, w_state_d;
  logic [2:0]        r_op, r_z;
  logic [LEN_W-1:0]  r_groups, r_step, w_step_d;
  logic [WcW-1:0]    r_wc, w_wc_d;
  logic [CntW-1:0]   r_rcnt, w_rcnt_d, r_wcnt, w_wcnt_d;
  logic [ADDR_W-1:0] r_addr, w_addr_d;
  logic              r_wr_en, r_rd_valid, r_rd_last, r_done, r_err;
  logic              w_rd_valid_d, w_rd_last_d, w_done_d, w_err_d;

  logic              w_accept, w_cmd_ok, w_start, w_len0, w_group_end;
  logic              w_src_load, w_src_step, w_dst_load, w_dst_step;
  logic [LEN_W-1:0]  w_groups_in;
  logic [ADDR_W-1:0] w_src_inc, w_src_next, w_dst_next;
  rw_t               w_rw_in, w_rw_q, w_rw_eff;

  // A command is only taken in a settled IDLE; the single done=0 cycle of a
  // zero-length command does not count as settled.
  assign w_accept    = (r_state == StIdle) && r_done && i_enable;
  assign w_cmd_ok    = op_legal(i_operation) && (32'(i_current_zoom) <= MAX_ZOOM);
  assign w_start     = w_accept && w_cmd_ok;
  assign w_groups_in = single_group(i_operation) ? LEN_W'(1) : i_length;
  assign w_rw_in     = per_group_rw(i_operation, i_current_zoom);
  assign w_rw_q      = per_group_rw(r_op, r_z);
  assign w_rw_eff    = w_start ? w_rw_in : w_rw_q;
  assign w_src_inc   = (r_op == OP_NH) ? (ADDR_W'(1) << r_z) : ADDR_W'(1);

  always_comb begin
    w_state_d   = r_state;
    w_wc_d      = r_wc;
    w_rcnt_d    = r_rcnt;
    w_wcnt_d    = r_wcnt;
    w_step_d    = r_step;
    w_src_load  = 1'b0;
    w_src_step  = 1'b0;
    w_dst_load  = 1'b0;
    w_dst_step  = 1'b0;
    w_err_d     = 1'b0;
    w_len0      = 1'b0;
    w_group_end = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (!w_cmd_ok) begin
            w_err_d = 1'b1;
          end else begin
            w_step_d   = '0;
            w_wc_d     = '0;
            w_rcnt_d   = '0;
            w_wcnt_d   = '0;
            w_src_load = 1'b1;
            w_dst_load = 1'b1;
            if (w_groups_in == '0) begin
              w_len0 = 1'b1;
            end else begin
              w_state_d = (w_rw_eff.rd != '0) ? StRead : StWrite;
            end
          end
        end
      end
      StRead: begin
        if (i_abort) begin
          w_state_d = StIdle;
        end else if (r_wc == WcLast) begin
          w_wc_d     = '0;
          w_src_step = 1'b1;
          if (r_rcnt == w_rw_eff.rd - CntW'(1)) begin
            w_rcnt_d = '0;
            if (w_rw_eff.wr != '0) begin
              w_state_d = StWrite;
            end else begin
              w_group_end = 1'b1;
            end
          end else begin
            w_rcnt_d = r_rcnt + CntW'(1);
          end
        end else begin
          w_wc_d = r_wc + WcW'(1);
        end
      end
      StWrite: begin
        if (i_abort) begin
          w_state_d = StIdle;
        end else if (r_wc == WcLast) begin
          w_wc_d     = '0;
          w_dst_step = 1'b1;
          if (r_wcnt == w_rw_eff.wr - CntW'(1)) begin
            w_wcnt_d    = '0;
            w_group_end = 1'b1;
          end else begin
            w_wcnt_d = r_wcnt + CntW'(1);
          end
        end else begin
          w_wc_d = r_wc + WcW'(1);
        end
      end
      default: w_state_d = StIdle;
    endcase

    if (w_group_end) begin
      w_step_d = r_step + LEN_W'(1);
      if (w_step_d == r_groups) begin
        w_state_d = StIdle;
      end else begin
        w_state_d = (w_rw_eff.rd != '0) ? StRead : StWrite;
      end
    end

    // Outputs are computed from the next state so they are valid from the
    // first cycle of each window.
    unique case (w_state_d)
      StRead:  w_addr_d = w_src_next;
      StWrite: w_addr_d = w_dst_next;
      default: w_addr_d = r_addr;
    endcase
    w_rd_valid_d = (w_state_d == StRead) && (w_wc_d == WcLast);
    w_rd_last_d  = w_rd_valid_d && (w_rcnt_d == w_rw_eff.rd - CntW'(1));
    w_done_d     = (w_state_d == StIdle) && !w_len0;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= StIdle;
      r_op       <= '0;
      r_z        <= '0;
      r_groups   <= '0;
      r_step     <= '0;
      r_wc       <= '0;
      r_rcnt     <= '0;
      r_wcnt     <= '0;
      r_addr     <= '0;
      r_wr_en    <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_done     <= 1'b1;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_step     <= w_step_d;
      r_wc       <= w_wc_d;
      r_rcnt     <= w_rcnt_d;
      r_wcnt     <= w_wcnt_d;
      r_addr     <= w_addr_d;
      r_wr_en    <= (w_state_d == StWrite);
      r_rd_valid <= w_rd_valid_d;
      r_rd_last  <= w_rd_last_d;
      r_done     <= w_done_d;
      r_err      <= w_err_d;
      if (w_start) begin
        r_op     <= i_operation;
        r_z      <= i_current_zoom;
        r_groups <= w_groups_in;
      end
    end
  end

  addr_stepper #(
    .ADDR_W    (ADDR_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_src (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_load     (w_src_load),
    .i_load_val (i_addr_base),
    .i_step     (w_src_step),
    .i_inc      (w_src_inc),
    .o_ptr_next (w_src_next)
  );

  addr_stepper #(
    .ADDR_W    (ADDR_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_dst (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_load     (w_dst_load),
    .i_load_val (i_addr_dst),
    .i_step     (w_dst_step),
    .i_inc      (ADDR_W'(1)),
    .o_ptr_next (w_dst_next)
  );

  assign o_addr_out   = r_addr;
  assign o_wr_enable  = r_wr_en;
  assign o_rd_valid   = r_rd_valid;
  assign o_rd_last    = r_rd_last;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_step_count = r_step;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer: a per-cycle expectation queue built from
// the algorithm table, checked every cycle, plus hand-computed literal checks.
module tb_mem_access_sequencer;

  localparam int unsigned ADDR_W    = 17;
  localparam int unsigned MEM_DEPTH = 76800;
  localparam int unsigned LEN_W     = 17;
  localparam int unsigned WAIT      = 3;
  localparam int unsigned MAX_ZOOM  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic [2:0]        operation = '0;
  logic [2:0]        zoom = '0;
  logic [ADDR_W-1:0] addr_base = '0;
  logic [ADDR_W-1:0] addr_dst = '0;
  logic [LEN_W-1:0]  length = '0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] addr_out;
  logic              wr_enable, rd_valid, rd_last, done, err;
  logic [LEN_W-1:0]  step_count;

  mem_access_sequencer #(
    .ADDR_W      (ADDR_W),
    .MEM_DEPTH   (MEM_DEPTH),
    .LEN_W       (LEN_W),
    .WAIT_CYCLES (WAIT),
    .MAX_ZOOM    (MAX_ZOOM)
  ) dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_enable       (enable),
    .i_operation    (operation),
    .i_current_zoom (zoom),
    .i_addr_base    (addr_base),
    .i_addr_dst     (addr_dst),
    .i_length       (length),
    .i_abort        (abort),
    .o_addr_out     (addr_out),
    .o_wr_enable    (wr_enable),
    .o_rd_valid     (rd_valid),
    .o_rd_last      (rd_last),
    .o_done         (done),
    .o_err          (err),
    .o_step_count   (step_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          chk;
    int unsigned addr;
    bit          wr;
    bit          rv;
    bit          rl;
    int unsigned step;
    bit          gend;
  } exp_t;

  exp_t        q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int unsigned idle_step = 0;
  int unsigned last_step = 0;
  bit          exp_err = 1'b0;
  int          busy_cnt = 0;
  int          err_cnt = 0;
  int unsigned obs_rd[$];
  bit          obs_rl[$];

  function automatic void check(input string name, input longint act, input longint req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Expected per-cycle behaviour of one command, expanded from the algorithm table.
  task automatic push_cmd(input int op, input int z, input int unsigned base,
                          input int unsigned dst, input int unsigned len);
    int unsigned r, w, g, sinc, s, d;
    exp_t e;
    if (op == 0 || op == 7 || z > MAX_ZOOM) begin
      exp_err = 1'b1;
      return;
    end
    r = 1; w = 1; g = len; sinc = 1;
    case (op)
      1: begin w = 0; g = 1; end
      2: begin r = 0; g = 1; end
      3: w = 1 << z;
      4: w = 1 << (2 * z);
      5: sinc = 1 << z;
      default: r = 1 << z;
    endcase
    s = base; d = dst;
    idle_step = 0;
    if (g == 0) begin
      e = '{chk: 0, addr: 0, wr: 0, rv: 0, rl: 0, step: 0, gend: 0};
      q.push_back(e);
      return;
    end
    for (int gi = 0; gi < int'(g); gi++) begin
      for (int ri = 0; ri < int'(r); ri++) begin
        for (int c = 0; c <= int'(WAIT); c++) begin
          e = '{chk: 1, addr: s, wr: 0, rv: (c == WAIT), rl: (c == WAIT && ri == r - 1),
                step: gi, gend: (c == WAIT && ri == r - 1 && w == 0)};
          q.push_back(e);
        end
        s = (s + sinc) % MEM_DEPTH;
      end
      for (int wi = 0; wi < int'(w); wi++) begin
        for (int c = 0; c <= int'(WAIT); c++) begin
          e = '{chk: 1, addr: d, wr: 1, rv: 0, rl: 0, step: gi,
                gend: (c == WAIT && wi == w - 1)};
          q.push_back(e);
        end
        d = (d + 1) % MEM_DEPTH;
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!done) busy_cnt++;
    if (err) err_cnt++;
    if (rd_valid) begin
      obs_rd.push_back(addr_out);
      obs_rl.push_back(rd_last);
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      check("busy_done", done, 0);
      check("wr_enable", wr_enable, e.wr);
      check("rd_valid", rd_valid, e.rv);
      check("rd_last", rd_last, e.rl);
      check("step_count", step_count, e.step);
      check("busy_err", err, 0);
      if (e.chk) check("addr_out", addr_out, e.addr);
      last_step = e.step;
      if (e.gend) idle_step = e.step + 1;
    end else begin
      check("idle_done", done, 1);
      check("idle_wr_enable", wr_enable, 0);
      check("idle_rd_valid", rd_valid, 0);
      check("idle_rd_last", rd_last, 0);
      check("idle_step_count", step_count, idle_step);
      check("idle_err", err, exp_err);
      exp_err = 1'b0;
    end
  end

  task automatic issue(input int op, input int z, input int unsigned base,
                       input int unsigned dst, input int unsigned len, input bit ab);
    @(posedge clk);
    #1;
    operation = 3'(op);
    zoom      = 3'(z);
    addr_base = base[ADDR_W-1:0];
    addr_dst  = dst[ADDR_W-1:0];
    length    = len[LEN_W-1:0];
    abort     = ab;
    enable    = 1'b1;
    @(posedge clk);
    busy_cnt = 0;
    err_cnt  = 0;
    obs_rd.delete();
    obs_rl.delete();
    push_cmd(op, z, base, dst, len);
    #1;
    enable    = 1'b0;
    abort     = 1'b0;
    operation = 3'b111;
    zoom      = 3'd7;
    addr_base = '1;
    addr_dst  = '1;
    length    = '1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #2;
      if (q.size() == 0 && done) begin
        ok = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_timeout: actual busy required idle within %0d cycles", name, budget);
      q.delete();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: actual still running required finished");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #2;
    check("rst_done", done, 1);
    check("rst_addr", addr_out, 0);
    check("rst_wr_enable", wr_enable, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_err", err, 0);
    check("rst_step", step_count, 0);
    #1 rst = 1'b0;

    // RD: one read held four cycles, rd_valid/rd_last in the last.
    issue(1, 0, 'h100, 'h2222, 5, 0);
    wait_idle("t1", 20);
    check("t1_busy", busy_cnt, 4);
    check("t1_nreads", obs_rd.size(), 1);
    if (obs_rd.size() == 1) begin
      check("t1_addr", obs_rd[0], 'h100);
      check("t1_last", obs_rl[0], 1);
    end
    check("t1_step", step_count, 1);

    // NHI z=1 len=2, with a stray enable while busy.
    issue(3, 1, 10, 50, 2, 0);
    repeat (3) @(posedge clk);
    #1 enable = 1'b1; operation = 3'b001;
    @(posedge clk);
    #1 enable = 1'b0;
    wait_idle("t2", 60);
    check("t2_busy", busy_cnt, 24);
    check("t2_step", step_count, 2);
    check("t2_nreads", obs_rd.size(), 2);
    if (obs_rd.size() == 2) begin
      check("t2_rd0", obs_rd[0], 10);
      check("t2_rd1", obs_rd[1], 11);
    end

    // BA z=2 with source wrap.
    issue(6, 2, 76798, 0, 1, 0);
    wait_idle("t3", 60);
    check("t3_busy", busy_cnt, 20);
    check("t3_nreads", obs_rd.size(), 4);
    if (obs_rd.size() == 4) begin
      check("t3_rd0", obs_rd[0], 76798);
      check("t3_rd1", obs_rd[1], 76799);
      check("t3_rd2", obs_rd[2], 0);
      check("t3_rd3", obs_rd[3], 1);
      check("t3_last0", obs_rl[0], 0);
      check("t3_last2", obs_rl[2], 0);
      check("t3_last3", obs_rl[3], 1);
    end

    // Illegal op and oversized zoom are rejected.
    issue(7, 0, 5, 5, 4, 0);
    wait_idle("t4a", 10);
    check("t4a_err_pulses", err_cnt, 1);
    check("t4a_busy", busy_cnt, 0);
    issue(1, 3, 5, 5, 4, 0);
    wait_idle("t4b", 10);
    check("t4b_err_pulses", err_cnt, 1);
    check("t4b_busy", busy_cnt, 0);

    // NH z=2: source stride of four.
    issue(5, 2, 0, 200, 3, 0);
    wait_idle("t4c", 60);
    check("t4c_busy", busy_cnt, 24);
    check("t4c_step", step_count, 3);
    check("t4c_nreads", obs_rd.size(), 3);
    if (obs_rd.size() == 3) begin
      check("t4c_rd0", obs_rd[0], 0);
      check("t4c_rd1", obs_rd[1], 4);
      check("t4c_rd2", obs_rd[2], 8);
    end

    // Zero-length algorithm command: done low exactly one cycle.
    issue(4, 1, 5, 5, 0, 0);
    wait_idle("len0", 10);
    check("len0_busy", busy_cnt, 1);
    check("len0_step", step_count, 0);

    // Abort together with enable in IDLE is ignored; WR runs.
    issue(2, 0, 0, 'h1234, 9, 1);
    wait_idle("wr", 20);
    check("wr_busy", busy_cnt, 4);
    check("wr_step", step_count, 1);

    // PR z=1 len=3, abort in the second write window (cycle 10).
    issue(4, 1, 20, 300, 3, 0);
    repeat (9) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    q.delete();
    idle_step = last_step;
    #1 abort = 1'b0;
    check("t5_wr_enable", wr_enable, 0);
    check("t5_done", done, 1);
    check("t5_step", step_count, 0);
    wait_idle("t5", 10);
    check("t5_busy", busy_cnt, 10);

    // Reset asserted in the write window of NHI z=0.
    issue(3, 0, 40, 60, 2, 0);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    q.delete();
    idle_step = 0;
    #1;
    check("t6_wr_enable", wr_enable, 0);
    check("t6_done", done, 1);
    check("t6_addr", addr_out, 0);
    check("t6_step", step_count, 0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    issue(1, 0, 'h0abc, 0, 1, 0);
    wait_idle("t6", 20);
    check("t6_busy", busy_cnt, 4);
    check("t6_nreads", obs_rd.size(), 1);
    if (obs_rd.size() == 1) check("t6_rd0", obs_rd[0], 'h0abc);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
